dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Parametrised, wait-state-capable data memory for the RISC CPU load/store path; successor to the fixed 8-bit/256-entry data memory.
- Adds a req/ready/ack handshake, programmable access latency, byte-lane write enables, and asynchronous reset of all control state.
- Sits between the execute-stage load/store unit and on-chip storage; the CPU stalls while `ready` is low or `ack` is pending.

Parameters:
- DATA_W, 8, data width in bits; must be a multiple of 8.
- ADDR_W, 8, address width in bits (word address).
- DEPTH, 256, number of words implemented; must satisfy DEPTH <= 2**ADDR_W.
- WAIT_CYCLES, 0, extra cycles inserted between acceptance and completion; range 0..15.
- BE_W (localparam), DATA_W/8, number of byte-lane enables.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  access request.
- we  in  1  1 = write, 0 = read; sampled at acceptance.
- addr  in  ADDR_W  word address; sampled at acceptance.
- wdata  in  DATA_W  write data; sampled at acceptance.
- be  in  BE_W  byte-lane write enables; ignored for reads.
- ready  out  1  controller can accept a request this cycle.
- ack  out  1  one-cycle completion pulse for both reads and writes.
- rdata  out  DATA_W  read data; valid only while ack=1 for a read, 0 otherwise.
- err  out  1  present only with DMEM_ERR_EN; see Optional Feature.

Behaviour:
- Reset (asynchronous on rst_n=0):
  - FSM goes to IDLE; wait counter = 0.
  - ready=1, ack=0, rdata=0, err=0; all captured-request registers cleared.
  - Memory array is not reset; its contents are undefined after power-up.
- FSM states: IDLE, WAIT, ACK.
  - ready = 1 in IDLE and in ACK; 0 in WAIT.
  - Acceptance = req && ready at a rising edge; we/addr/wdata/be are captured on that edge.
  - On acceptance with WAIT_CYCLES=0: the access executes on the same edge; next state is ACK.
  - On acceptance with WAIT_CYCLES>0: next state is WAIT; counter loads WAIT_CYCLES-1.
  - WAIT: counter decrements each cycle. When the counter reaches 0, the access executes on that edge and the next state is ACK.
  - ACK: ack=1 for exactly one cycle. A new acceptance in this cycle follows the same rules as in IDLE (back-to-back). Without acceptance, next state is IDLE.
- Latency: ack is asserted in the cycle exactly 1+WAIT_CYCLES cycles after the accept cycle. Throughput is one access per 1+WAIT_CYCLES cycles.
- Execute, write: byte lane i of the array is updated with wdata lane i only where be[i]=1. be=0 is a legal no-op write that still acks.
- Execute, read: rdata is loaded with the array word at the captured address and held only for the ack cycle. At every other time rdata=0, including during write acks.
- Read-after-write to the same address in consecutive accesses returns the newly written data; writes commit before the next access executes.
- req while ready=0 is ignored; the requester must hold req until accepted.
- Reset mid-access: an access not yet executed is dropped (no array write, no ack). An already-executed write stays committed.
- Out-of-range access (addr >= DEPTH): the write is dropped, the read returns 0, and ack is still generated.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined:
  - The err port exists.
  - err=1 together with ack for any out-of-range access; err=0 in all other cycles; reset value 0.
  - A write with be=0 also flags err.
- Undefined:
  - The err port is absent; out-of-range handling is silent as described above.
  - be=0 is a silent no-op.

Decomposition:
- dmem_pkg:
  - FSM state encodings IDLE/WAIT/ACK.
  - Width constant for the wait counter (4 bits).
  - BE_W derivation helper.
  - Default parameter constants shared with the CPU top level.
- Sub-module dmem_array:
  - Parameters DATA_W/DEPTH.
  - Synchronous write with byte enables; synchronous read with read-enable; no reset.
- dmem_ctrl holds the FSM, counter, capture registers, range check, and err logic.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT (WAIT_CYCLES=3) -> ready=1, ack=0, rdata=0 immediately; the pending write to 0x10 is absent on a later read.
- WAIT_CYCLES=0: write 0xA5 to 0x3C, then a back-to-back read of 0x3C accepted during the ack cycle -> second ack one cycle later with rdata=0xA5.
- WAIT_CYCLES=2: read accepted at cycle N -> ready=0 in cycles N+1..N+2, ack and valid rdata in cycle N+3, rdata=0 in cycle N+4.
- DATA_W=32: write 0x11223344 with be=4'b1111, then 0xAABBCCDD with be=4'b0101 to the same address -> read returns 0x11BB33DD.
- DEPTH=200, ADDR_W=8: write 0x77 to address 0xF0, then read 0xF0 -> ack with rdata=0; with DMEM_ERR_EN, err=1 on both acks.
- req held while ready=0 during WAIT -> exactly one access is accepted per ack; no duplicate writes (check with a scoreboard over 1000 random accesses).

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data memory controller.
// FSM encoding, wait counter width, lane-width helpers, CPU-level defaults.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } dmem_state_e;

  localparam int CNT_W = 4;

  localparam int DMEM_DATA_W      = 8;
  localparam int DMEM_ADDR_W      = 8;
  localparam int DMEM_DEPTH       = 256;
  localparam int DMEM_WAIT_CYCLES = 0;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: byte-lane writable storage, synchronous read, no reset.
// Ports: clk, we/be/waddr/wdata write port, re/raddr/rdata read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [be_width(DATA_W)-1:0]    be,
  input  logic [idx_width(DEPTH)-1:0]    waddr,
  input  logic [DATA_W-1:0]              wdata,
  input  logic                           re,
  input  logic [idx_width(DEPTH)-1:0]    raddr,
  output logic [DATA_W-1:0]              rdata
);

  localparam int BE_W = be_width(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: req/ready/ack data memory with wait states and byte enables.
// Ports: clk, rst_n, req/we/addr/wdata/be in; ready/ack/rdata (+err if DMEM_ERR_EN) out.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter  int DATA_W      = DMEM_DATA_W,
  parameter  int ADDR_W      = DMEM_ADDR_W,
  parameter  int DEPTH       = DMEM_DEPTH,
  parameter  int WAIT_CYCLES = DMEM_WAIT_CYCLES,
  localparam int BE_W        = be_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic              ready,
  output logic              ack,
`ifdef DMEM_ERR_EN
  output logic              err,
`endif
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  dmem_state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              rd_q, rd_d;
`ifdef DMEM_ERR_EN
  logic              err_q, err_d;
`endif

  logic              accept;
  logic              exec;
  logic              in_rng;
  logic              x_we;
  logic [ADDR_W-1:0] x_addr;
  logic [DATA_W-1:0] x_wdata;
  logic [BE_W-1:0]   x_be;
  logic [DATA_W-1:0] arr_rdata;

  assign accept = req && ready;

  // Zero-wait accesses execute straight from the port;
  // waited ones execute from the captured copy.
  always_comb begin
    x_we    = we;
    x_addr  = addr;
    x_wdata = wdata;
    x_be    = be;
    if (state_q == ST_WAIT) begin
      x_we    = we_q;
      x_addr  = addr_q;
      x_wdata = wdata_q;
      x_be    = be_q;
    end
    in_rng = {1'b0, x_addr} < DEPTH_X;
    exec   = (accept && (WAIT_CYCLES == 0))
          || ((state_q == ST_WAIT) && (cnt_q == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_ACK: begin
        state_d = ST_IDLE;
        if (accept) begin
          state_d = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q != ST_WAIT);
    ack   = (state_q == ST_ACK);
    rdata = (ack && rd_q) ? arr_rdata : '0;
`ifdef DMEM_ERR_EN
    err   = ack && err_q;
`endif
  end

  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    if (accept) begin
      we_d    = we;
      addr_d  = addr;
      wdata_d = wdata;
      be_d    = be;
    end
    if (exec) begin
      rd_d = !x_we && in_rng;
    end
  end

`ifdef DMEM_ERR_EN
  always_comb begin
    err_d = err_q;
    if (exec) begin
      err_d = !in_rng || (x_we && (x_be == '0));
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
`ifdef DMEM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
`ifdef DMEM_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (exec && x_we && in_rng),
    .be    (x_be),
    .waddr (x_addr[IDX_W-1:0]),
    .wdata (x_wdata),
    .re    (exec && !x_we && in_rng),
    .raddr (x_addr[IDX_W-1:0]),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for two dmem_ctrl configurations.
// A: 32-bit, DEPTH 200, 2 wait states. B: 8-bit, DEPTH 256, no wait.
`timescale 1ns/1ps
module tb_dmem_ctrl;

  localparam int DW_A    = 32;
  localparam int DEPTH_A = 200;
  localparam int WAIT_A  = 2;
  localparam int DW_B    = 8;
  localparam int DEPTH_B = 256;

  typedef struct {
    int          cyc;
    logic [31:0] rd;
    logic        er;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_on = 1'b0;

  logic            rst_a_n, req_a, we_a, ready_a, ack_a, err_a;
  logic [7:0]      addr_a;
  logic [DW_A-1:0] wdata_a, rdata_a;
  logic [3:0]      be_a;

  logic            rst_b_n, req_b, we_b, ready_b, ack_b, err_b;
  logic [7:0]      addr_b;
  logic [DW_B-1:0] wdata_b, rdata_b;
  logic [0:0]      be_b;

  dmem_ctrl #(
    .DATA_W(DW_A), .ADDR_W(8), .DEPTH(DEPTH_A), .WAIT_CYCLES(WAIT_A)
  ) dut_a (
    .clk(clk), .rst_n(rst_a_n), .req(req_a), .we(we_a),
    .addr(addr_a), .wdata(wdata_a), .be(be_a),
    .ready(ready_a), .ack(ack_a),
`ifdef DMEM_ERR_EN
    .err(err_a),
`endif
    .rdata(rdata_a)
  );

  dmem_ctrl #(
    .DATA_W(DW_B), .ADDR_W(8), .DEPTH(DEPTH_B), .WAIT_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_b_n), .req(req_b), .we(we_b),
    .addr(addr_b), .wdata(wdata_b), .be(be_b),
    .ready(ready_b), .ack(ack_b),
`ifdef DMEM_ERR_EN
    .err(err_b),
`endif
    .rdata(rdata_b)
  );

`ifndef DMEM_ERR_EN
  assign err_a = 1'b0;
  assign err_b = 1'b0;
`endif

  exp_t qa[$];
  exp_t qb[$];
  logic [31:0] ma [DEPTH_A];
  logic [7:0]  mb [DEPTH_B];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  // Reference: serialized accesses on a plain word array.
  function automatic exp_t model_a(input bit w, input logic [7:0] ad,
                                   input logic [31:0] d,
                                   input logic [3:0] b);
    exp_t e;
    bit oor;
    oor  = (int'(ad) >= DEPTH_A);
    e.cyc = 0;
    e.rd = '0;
    e.er = oor || (w && (b == 4'h0));
    if (!oor) begin
      if (w) begin
        for (int i = 0; i < 4; i++) begin
          if (b[i]) ma[ad][8*i +: 8] = d[8*i +: 8];
        end
      end else begin
        e.rd = ma[ad];
      end
    end
    return e;
  endfunction

  function automatic exp_t model_b(input bit w, input logic [7:0] ad,
                                   input logic [7:0] d, input logic b);
    exp_t e;
    e.cyc = 0;
    e.rd = '0;
    e.er = w && !b;
    if (w) begin
      if (b) mb[ad] = d;
    end else begin
      e.rd = {24'h0, mb[ad]};
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic acc_a(input bit w, input logic [7:0] ad,
                       input logic [31:0] d, input logic [3:0] b);
    exp_t e;
    int n;
    req_a = 1'b1; we_a = w; addr_a = ad; wdata_a = d; be_a = b;
    n = 0;
    while (!ready_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_a) begin
      chk("a_ready_timeout", 32'(ready_a), 32'd1);
    end else begin
      e = model_a(w, ad, d, b);
      e.cyc = cyc + 1 + WAIT_A;
      qa.push_back(e);
    end
    @(negedge clk);
    req_a = 1'b0;
  endtask

  task automatic acc_b(input bit w, input logic [7:0] ad,
                       input logic [7:0] d, input logic b);
    exp_t e;
    int n;
    req_b = 1'b1; we_b = w; addr_b = ad; wdata_b = d; be_b = b;
    n = 0;
    while (!ready_b && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_b) begin
      chk("b_ready_timeout", 32'(ready_b), 32'd1);
    end else begin
      e = model_b(w, ad, d, b);
      e.cyc = cyc + 1;
      qb.push_back(e);
    end
    @(negedge clk);
    req_b = 1'b0;
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (mon_on) begin
      if (ack_a === 1'b1) begin
        if (qa.size() == 0) begin
          chk("a_spurious_ack", 32'(ack_a), 32'd0);
        end else begin
          e = qa.pop_front();
          chk("a_latency", 32'(cyc), 32'(e.cyc));
          chk("a_rdata", rdata_a, e.rd);
`ifdef DMEM_ERR_EN
          chk("a_err", 32'(err_a), 32'(e.er));
`endif
        end
      end else begin
        chk("a_ack_idle", 32'(ack_a), 32'd0);
        chk("a_rdata_idle", rdata_a, 32'd0);
`ifdef DMEM_ERR_EN
        chk("a_err_idle", 32'(err_a), 32'd0);
`endif
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (mon_on) begin
      if (ack_b === 1'b1) begin
        if (qb.size() == 0) begin
          chk("b_spurious_ack", 32'(ack_b), 32'd0);
        end else begin
          e = qb.pop_front();
          chk("b_latency", 32'(cyc), 32'(e.cyc));
          chk("b_rdata", 32'(rdata_b), e.rd);
`ifdef DMEM_ERR_EN
          chk("b_err", 32'(err_b), 32'(e.er));
`endif
        end
      end else begin
        chk("b_ack_idle", 32'(ack_b), 32'd0);
        chk("b_rdata_idle", 32'(rdata_b), 32'd0);
      end
    end
  end

  task automatic run_a();
    for (int i = 0; i < DEPTH_A; i++) begin
      acc_a(1'b1, 8'(i), $urandom, 4'hF);
    end
    acc_a(1'b1, 8'h05, 32'h11223344, 4'hF);
    acc_a(1'b1, 8'h05, 32'hAABBCCDD, 4'h5);
    acc_a(1'b0, 8'h05, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    acc_a(1'b0, 8'h20, 32'h0, 4'h0);
    chk("a_wait_ready_n1", 32'(ready_a), 32'd0);
    @(negedge clk);
    chk("a_wait_ready_n2", 32'(ready_a), 32'd0);
    @(negedge clk);
    chk("a_ack_ready_n3", 32'(ready_a), 32'd1);
    acc_a(1'b1, 8'hF0, 32'h77, 4'hF);
    acc_a(1'b0, 8'hF0, 32'h0, 4'h0);
    acc_a(1'b1, 8'h07, 32'h12345678, 4'h0);
    acc_a(1'b0, 8'h07, 32'h0, 4'h0);
    repeat (4) @(negedge clk);
    req_a = 1'b1; we_a = 1'b1; addr_a = 8'h10;
    wdata_a = 32'hDEADBEEF; be_a = 4'hF;
    @(negedge clk);
    req_a = 1'b0;
    chk("a_pre_rst_wait", 32'(ready_a), 32'd0);
    rst_a_n = 1'b0;
    #1;
    chk("a_rst_ready", 32'(ready_a), 32'd1);
    chk("a_rst_ack", 32'(ack_a), 32'd0);
    chk("a_rst_rdata", rdata_a, 32'd0);
    @(negedge clk);
    rst_a_n = 1'b1;
    acc_a(1'b0, 8'h10, 32'h0, 4'h0);
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      acc_a(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            $urandom, 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic run_b();
    for (int i = 0; i < DEPTH_B; i++) begin
      acc_b(1'b1, 8'(i), 8'($urandom), 1'b1);
    end
    acc_b(1'b1, 8'h3C, 8'hA5, 1'b1);
    acc_b(1'b0, 8'h3C, 8'h00, 1'b0);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
      end
      acc_b(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            8'($urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0; be_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0; be_b = '0;
    repeat (3) @(negedge clk);
    chk("a_reset_ready", 32'(ready_a), 32'd1);
    chk("a_reset_ack", 32'(ack_a), 32'd0);
    chk("a_reset_rdata", rdata_a, 32'd0);
    chk("a_reset_err", 32'(err_a), 32'd0);
    chk("b_reset_ready", 32'(ready_b), 32'd1);
    chk("b_reset_ack", 32'(ack_b), 32'd0);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);
    fork
      run_a();
      run_b();
    join
    repeat (10) @(negedge clk);
    chk("a_drain", 32'(qa.size()), 32'd0);
    chk("b_drain", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
